// File: rtl/rr_arb_mux.sv
// rr_arb_mux: CH-input, N-bit arbitrating multiplexer with a one-entry
// registered output. Channels are picked either round-robin (MODE 0)
// or by fixed priority, lowest index first (MODE 1).
//
// Handshake: a word moves on any port when valid and ready are both high
// at a rising clock edge. A source holds valid and data stable until it is
// accepted, and its valid never depends on its ready. in_ready depends
// combinationally on in_valid and out_ready. out_valid is taken from the
// register only.
module rr_arb_mux #(
  parameter  int N    = 32,
  parameter  int CH   = 4,
  parameter  int MODE = 0,
  localparam int CW   = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH-1:0]   in_valid,
  input  logic [CH*N-1:0] in_data,
  output logic [CH-1:0]   in_ready,
  output logic            out_valid,
  output logic [N-1:0]    out_data,
  output logic [CW-1:0]   out_ch,
  input  logic            out_ready
);

  localparam logic [CW-1:0] LAST = CW'(CH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [N-1:0]  ch_data [CH];
  logic [CH-1:0] grant;
  logic [CW-1:0] gnt_idx;
  logic [CW-1:0] ptr;
  logic          load;
  logic          xfer;

  // Unpack the flat data bus into one word per channel.
  for (genvar i = 0; i < CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*N +: N];
  end

  // The output register can take a new word when it is empty or draining.
  assign load = ~out_valid | out_ready;

  // Find the first requesting channel, starting at ptr (round-robin) or at
  // channel 0 (fixed priority). Wrapping is done by subtraction so that a
  // non-power-of-2 CH never yields an index outside 0..CH-1.
  always_comb begin : arb_pick
    int   idx;
    logic found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < CH; k++) begin
      idx = (MODE == 1) ? k : int'(ptr) + k;
      if (idx >= CH) idx = idx - CH;
      if (!found && in_valid[CW'(idx)]) begin
        found             = 1'b1;
        grant[CW'(idx)]   = 1'b1;
        gnt_idx           = CW'(idx);
      end
    end
  end

  // A grant only exists on a valid channel, so any grant under load transfers.
  assign xfer     = load & (|grant);
  assign in_ready = (load && !rst) ? grant : '0;

  // Output register and round-robin pointer: load on transfer, clear
  // out_valid on a drain with nothing new, hold everything on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt_idx];
        out_ch    <= gnt_idx;
        if (MODE == 0) ptr <= (gnt_idx == LAST) ? '0 : gnt_idx + ONE;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
